// File: rtl/display_scan.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Optional macro DISPLAY_BLANK_EN blanks the first GAP cycles of every slot.
module display_scan #(
    parameter int unsigned DIGITOS = 4,
    parameter int unsigned DIV     = 50000,
    parameter int unsigned GAP     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [4*DIGITOS-1:0]   valor,
    input  logic [DIGITOS-1:0]     puntos,
    input  logic                   cargar,
    output logic                   ocupado,
    output logic [6:0]             catodo,
    output logic                   punto,
    output logic [DIGITOS-1:0]     anodo
);

    localparam int unsigned CW = $clog2(DIV);
    localparam int unsigned IW = $clog2(DIGITOS);

`ifdef DISPLAY_BLANK_EN
    localparam bit BlankEn = 1'b1;
`else
    localparam bit BlankEn = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [4*DIGITOS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITOS-1:0]     pend_pts_q, pend_pts_d;
    logic [4*DIGITOS-1:0]   shown_val_q, shown_val_d;
    logic [DIGITOS-1:0]     shown_pts_q, shown_pts_d;
    logic [6:0]             catodo_q, catodo_d;
    logic                   punto_q, punto_d;
    logic [DIGITOS-1:0]     anodo_q, anodo_d;

    logic                   slot_end;
    logic                   boundary;
    logic                   blank;
    logic [3:0]             nib;
    logic                   dp;
    logic [6:0]             seg;

    assign slot_end = (cnt_q == CW'(DIV - 1));
    assign boundary = slot_end && (idx_q == IW'(DIGITOS - 1));
    assign blank    = BlankEn && (cnt_q < CW'(GAP));

    // Prescaler and digit index
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            if (idx_q == IW'(DIGITOS - 1)) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IW'(1);
            end
        end
    end

    // Load FSM: pending commits to shown only at a frame boundary
    always_comb begin
        state_d     = state_q;
        pend_val_d  = pend_val_q;
        pend_pts_d  = pend_pts_q;
        shown_val_d = shown_val_q;
        shown_pts_d = shown_pts_q;
        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            PEND: begin
                if (boundary) begin
                    shown_val_d = pend_val_q;
                    shown_pts_d = pend_pts_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (cargar) begin
            pend_val_d = valor;
            pend_pts_d = puntos;
            state_d    = PEND;
        end
    end

    always_comb begin
        nib = 4'h0;
        dp  = 1'b0;
        for (int i = 0; i < int'(DIGITOS); i++) begin
            if (idx_q == IW'(i)) begin
                nib = shown_val_q[i*4 +: 4];
                dp  = shown_pts_q[i];
            end
        end
    end

    always_comb begin
        seg = 7'h00;
        unique case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
    end

    always_comb begin
        catodo_d = ~seg;
        punto_d  = ~dp;
        anodo_d  = '1;
        for (int i = 0; i < int'(DIGITOS); i++) begin
            anodo_d[i] = ~(idx_q == IW'(i));
        end
        if (blank) begin
            catodo_d = 7'h7F;
            punto_d  = 1'b1;
            anodo_d  = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            pend_val_q  <= '0;
            pend_pts_q  <= '0;
            shown_val_q <= '0;
            shown_pts_q <= '0;
            catodo_q    <= 7'h7F;
            punto_q     <= 1'b1;
            anodo_q     <= '1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            pend_val_q  <= pend_val_d;
            pend_pts_q  <= pend_pts_d;
            shown_val_q <= shown_val_d;
            shown_pts_q <= shown_pts_d;
            catodo_q    <= catodo_d;
            punto_q     <= punto_d;
            anodo_q     <= anodo_d;
        end
    end

    assign ocupado = (state_q == PEND);
    assign catodo  = catodo_q;
    assign punto   = punto_q;
    assign anodo   = anodo_q;

endmodule
